n2r_w_sched: RTL and testbench

//   Run controller and slice dispatcher for the weight-matrix normal-to-ready buffer.
//   - Resets the buffer, then streams ROW rows from a row-major weight source (1-cycle read latency).
//   - Collects the BLOCK_SIZE x CHUNK_SIZE slices the buffer emits and hands them round-robin to NUM_CORES MAC cores.
//   - Flags slices lost to core backpressure and buffer stalls.

---
 rtl/n2r_w_sched.sv | 168 ++++++++++++++++
 tb/tb_n2r_w_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n2r_w_sched.sv
// Run controller for the weight normal-to-ready buffer: clears the buffer, streams
// the weight rows into it, then deals the emitted slices round-robin to the MAC cores.
module n2r_w_sched #(
  parameter int WIDTH        = 16,
  parameter int ROW          = 256,
  parameter int COL          = 64,
  parameter int BLOCK_SIZE   = 2,
  parameter int CHUNK_SIZE   = 4,
  parameter int NUM_CORES    = 4,
  parameter int TIMEOUT      = 64,
  parameter int OUTPUT_WIDTH = WIDTH * BLOCK_SIZE * (CHUNK_SIZE / 2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    src_rd,
  output logic [$clog2(ROW)-1:0]  src_addr,
  output logic                    buf_rst_n,
  output logic                    buf_en,
  input  logic                    buf_output_ready,
  input  logic                    buf_buffer_done,
  input  logic [OUTPUT_WIDTH-1:0] buf_data,
  input  logic [NUM_CORES-1:0]    core_ready,
  output logic [NUM_CORES-1:0]    core_valid,
  output logic [OUTPUT_WIDTH-1:0] core_data,
  output logic                    core_last
);

  localparam int N_SLICE = (ROW / BLOCK_SIZE) * (COL / CHUNK_SIZE);
  localparam int AW      = $clog2(ROW);
  localparam int CW      = $clog2(N_SLICE) + 1;
  localparam int PW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                  state_q;
  logic                    busy_q, done_q, err_q;
  logic                    src_rd_q, buf_rst_n_q, buf_en_q, core_last_q;
  logic [AW-1:0]           src_addr_q;
  logic [NUM_CORES-1:0]    core_valid_q;
  logic [OUTPUT_WIDTH-1:0] core_data_q;
  logic                    clr_q;
  logic [CW-1:0]           cnt_q;
  logic [PW-1:0]           ptr_q;
  logic [IW-1:0]           idle_q;

  // Sequencing ignores buf_buffer_done; the slice count alone ends a run.
  logic unused_ok;
  assign unused_ok = buf_buffer_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      src_rd_q     <= 1'b0;
      src_addr_q   <= '0;
      buf_rst_n_q  <= 1'b0;
      buf_en_q     <= 1'b0;
      core_valid_q <= '0;
      core_data_q  <= '0;
      core_last_q  <= 1'b0;
      clr_q        <= 1'b0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      idle_q       <= '0;
    end else begin
      done_q       <= 1'b0;
      core_valid_q <= '0;
      core_last_q  <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        src_rd_q    <= 1'b0;
        buf_en_q    <= 1'b0;
        buf_rst_n_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            buf_rst_n_q <= 1'b0;
            if (start && !abort) begin
              err_q      <= 1'b0;
              ptr_q      <= '0;
              cnt_q      <= '0;
              idle_q     <= '0;
              clr_q      <= 1'b0;
              src_addr_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_CLR;
            end
          end
          S_CLR: begin
            if (clr_q) begin
              state_q     <= S_LOAD;
              buf_rst_n_q <= 1'b1;
              src_rd_q    <= 1'b1;
              src_addr_q  <= '0;
              buf_en_q    <= 1'b1;
            end else begin
              clr_q <= 1'b1;
            end
          end
          S_LOAD: begin
            // buf_en stays high one cycle into DRAIN to catch the last row's read data.
            if (src_addr_q == AW'(ROW - 1)) begin
              src_rd_q <= 1'b0;
              idle_q   <= '0;
              state_q  <= S_DRAIN;
            end else begin
              src_addr_q <= src_addr_q + 1'b1;
            end
          end
          S_DRAIN: begin
            buf_en_q <= 1'b0;
            if (cnt_q == CW'(N_SLICE)) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if (buf_output_ready) begin
              core_data_q  <= buf_data;
              core_valid_q <= NUM_CORES'(1) << ptr_q;
              core_last_q  <= (cnt_q == CW'(N_SLICE - 1));
              if (!core_ready[ptr_q]) err_q <= 1'b1;
              ptr_q  <= (ptr_q == PW'(NUM_CORES - 1)) ? '0 : ptr_q + 1'b1;
              cnt_q  <= cnt_q + 1'b1;
              idle_q <= '0;
            end else if (idle_q == IW'(TIMEOUT)) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
          S_FIN: begin
            busy_q      <= 1'b0;
            buf_rst_n_q <= 1'b0;
            state_q     <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign src_rd     = src_rd_q;
  assign src_addr   = src_addr_q;
  assign buf_rst_n  = buf_rst_n_q;
  assign buf_en     = buf_en_q;
  assign core_valid = core_valid_q;
  assign core_data  = core_data_q;
  assign core_last  = core_last_q;

endmodule

// File: tb/tb_n2r_w_sched.sv
// Bench for n2r_w_sched: a behavioural buffer driver plus a monitor that records the
// read, slice and done traffic, compared against expectations derived from the run rules.
module tb_n2r_w_sched;

  localparam int WIDTH = 16;
  localparam int ROW   = 8;
  localparam int COL   = 16;
  localparam int BS    = 2;
  localparam int CS    = 4;
  localparam int NC    = 4;
  localparam int TO    = 64;
  localparam int OW    = WIDTH * BS * (CS / 2);
  localparam int NS    = (ROW / BS) * (COL / CS);
  localparam int AW    = $clog2(ROW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, err, src_rd, buf_rst_n, buf_en, core_last;
  logic [AW-1:0] src_addr;
  logic          buf_output_ready = 1'b0;
  logic          buf_buffer_done = 1'b0;
  logic [OW-1:0] buf_data = '0;
  logic [NC-1:0] core_ready = '1;
  logic [NC-1:0] core_valid;
  logic [OW-1:0] core_data;

  int total = 0;
  int bad   = 0;

  n2r_w_sched #(
    .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .BLOCK_SIZE(BS), .CHUNK_SIZE(CS),
    .NUM_CORES(NC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .src_rd(src_rd), .src_addr(src_addr),
    .buf_rst_n(buf_rst_n), .buf_en(buf_en),
    .buf_output_ready(buf_output_ready), .buf_buffer_done(buf_buffer_done),
    .buf_data(buf_data),
    .core_ready(core_ready), .core_valid(core_valid),
    .core_data(core_data), .core_last(core_last)
  );

  always #5 clk = ~clk;

  // Monitor: everything observed at the falling edge, away from the DUT's active edge.
  int            cyc = 0;
  int            rd_q[$];
  logic [NC-1:0] cv_q[$];
  logic [OW-1:0] cd_q[$];
  logic          cl_q[$];
  int            done_n = 0, done_cyc = 0, last_cyc = 0, buf_en_n = 0, clr_n = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (src_rd) rd_q.push_back(int'(src_addr));
      if (buf_en) buf_en_n++;
      if (busy && !buf_rst_n) clr_n++;
      if (core_valid != '0) begin
        cv_q.push_back(core_valid);
        cd_q.push_back(core_data);
        cl_q.push_back(core_last);
        if (core_last) last_cyc = cyc;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  logic [OW-1:0] exp_q[$];

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Behavioural buffer: waits for the load phase to finish, then emits n slices with random gaps.
  task automatic feed(input int n, input int maxgap, input int start_at);
    int guard = 0;
    while (!src_rd && guard < 100) begin @(negedge clk); guard++; end
    while (src_rd && guard < 100) begin @(negedge clk); guard++; end
    total++;
    if (guard >= 100) begin
      bad++;
      $display("FAIL feed_wait: load phase not seen, waited %0d want <100", guard);
    end
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      buf_output_ready = 1'b1;
      buf_data = {$urandom(), $urandom()};
      exp_q.push_back(buf_data);
      start = (k == start_at);
      @(negedge clk);
      buf_output_ready = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int lim);
    int i = 0;
    while (!done && i < lim) begin @(negedge clk); i++; end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL done_timeout: done not seen after %0d cycles", i);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, err, src_rd, buf_rst_n, buf_en, core_last} !== 7'b0 || src_addr !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b addr %0d want 0000000 addr 0",
               {busy, done, err, src_rd, buf_rst_n, buf_en, core_last}, src_addr);
    end
    total++;
    if (core_valid !== '0 || core_data !== '0) begin
      bad++;
      $display("FAIL reset_core: got valid %b data %h want 0", core_valid, core_data);
    end
  endtask

  task automatic test_nominal();
    int rb = rd_q.size(), sb = cv_q.size(), eb = exp_q.size();
    int d0 = done_n, be0 = buf_en_n, c0 = clr_n;
    core_ready = '1;
    start_run();
    feed(NS, 3, -1);
    wait_done(300);
    total++;
    if (rd_q.size() - rb != ROW) begin
      bad++; $display("FAIL nom_rd_count: got %0d want %0d", rd_q.size() - rb, ROW);
    end else begin
      for (int k = 0; k < ROW; k++) begin
        total++;
        if (rd_q[rb + k] != k) begin
          bad++; $display("FAIL nom_addr[%0d]: got %0d want %0d", k, rd_q[rb + k], k);
        end
      end
    end
    total++;
    if (buf_en_n - be0 != ROW + 1) begin
      bad++; $display("FAIL nom_buf_en: got %0d cycles want %0d", buf_en_n - be0, ROW + 1);
    end
    total++;
    if (clr_n - c0 != 2) begin
      bad++; $display("FAIL nom_clr: got %0d cycles want 2", clr_n - c0);
    end
    total++;
    if (cv_q.size() - sb != NS) begin
      bad++; $display("FAIL nom_slices: got %0d want %0d", cv_q.size() - sb, NS);
    end else begin
      for (int k = 0; k < NS; k++) begin
        total++;
        if (cv_q[sb + k] !== NC'(1 << (k % NC)) || cd_q[sb + k] !== exp_q[eb + k]
            || cl_q[sb + k] !== (k == NS - 1)) begin
          bad++;
          $display("FAIL nom_slice[%0d]: got v=%b d=%h l=%b want v=%b d=%h l=%b", k,
                   cv_q[sb + k], cd_q[sb + k], cl_q[sb + k], NC'(1 << (k % NC)),
                   exp_q[eb + k], (k == NS - 1));
        end
      end
    end
    total++;
    if (done_n - d0 != 1 || done_cyc - last_cyc != 1) begin
      bad++; $display("FAIL nom_done: got %0d pulses lag %0d want 1 pulse lag 1",
                      done_n - d0, done_cyc - last_cyc);
    end
    total++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL nom_end: got err=%b busy=%b want 0 0", err, busy);
    end
  endtask

  task automatic test_core_ready(input logic [NC-1:0] mask, input int maxgap);
    int sb = cv_q.size(), eb = exp_q.size(), d0 = done_n;
    logic exp_err = 1'b0;
    core_ready = mask;
    for (int k = 0; k < NS; k++) if (!mask[k % NC]) exp_err = 1'b1;
    start_run();
    feed(NS, maxgap, -1);
    wait_done(300);
    total++;
    if (cv_q.size() - sb != NS) begin
      bad++; $display("FAIL rdy_slices mask=%b: got %0d want %0d", mask, cv_q.size() - sb, NS);
    end else begin
      for (int k = 0; k < NS; k++) begin
        total++;
        if (cv_q[sb + k] !== NC'(1 << (k % NC)) || cd_q[sb + k] !== exp_q[eb + k]) begin
          bad++;
          $display("FAIL rdy_slice[%0d] mask=%b: got v=%b d=%h want v=%b d=%h", k, mask,
                   cv_q[sb + k], cd_q[sb + k], NC'(1 << (k % NC)), exp_q[eb + k]);
        end
      end
    end
    total++;
    if (err !== exp_err || done_n - d0 != 1) begin
      bad++; $display("FAIL rdy_err mask=%b: got err=%b done=%0d want err=%b done=1",
                      mask, err, done_n - d0, exp_err);
    end
    core_ready = '1;
  endtask

  task automatic test_timeout();
    int sb = cv_q.size(), d0 = done_n, n = 0;
    core_ready = '1;
    start_run();
    feed(5, 2, -1);
    while (!err && n < 200) begin @(negedge clk); n++; end
    total++;
    if (n < 63 || n > 67) begin
      bad++; $display("FAIL to_latency: got err after %0d idle cycles want ~%0d", n, TO);
    end
    wait_done(20);
    total++;
    if (cv_q.size() - sb != 5 || done_n - d0 != 1 || err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL to_end: got slices=%0d done=%0d err=%b busy=%b want 5 1 1 0",
                      cv_q.size() - sb, done_n - d0, err, busy);
    end
  endtask

  task automatic test_abort();
    int d0 = done_n, guard = 0, rb;
    start_run();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL ab_start: got err=%b busy=%b want 0 1", err, busy);
    end
    while (!(src_rd && src_addr == AW'(3)) && guard < 50) begin @(negedge clk); guard++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy, src_rd, buf_en, buf_rst_n} !== 4'b0) begin
      bad++; $display("FAIL ab_idle: got busy/rd/en/rstn=%b want 0000",
                      {busy, src_rd, buf_en, buf_rst_n});
    end
    repeat (5) @(negedge clk);
    total++;
    if (done_n != d0 || busy !== 1'b0) begin
      bad++; $display("FAIL ab_nodone: got done=%0d busy=%b want 0 0", done_n - d0, busy);
    end
    rb = rd_q.size();
    start_run();
    feed(NS, 1, -1);
    wait_done(300);
    total++;
    if (rd_q.size() - rb != ROW || rd_q[rb] != 0 || err !== 1'b0 || done_n - d0 != 1) begin
      bad++; $display("FAIL ab_rerun: got reads=%0d first=%0d err=%b done=%0d want %0d 0 0 1",
                      rd_q.size() - rb, rd_q[rb], err, done_n - d0, ROW);
    end
  endtask

  task automatic test_start_in_drain();
    int rb = rd_q.size(), sb = cv_q.size(), d0 = done_n;
    start_run();
    feed(NS, 2, 7);
    wait_done(300);
    repeat (10) @(negedge clk);
    total++;
    if (done_n - d0 != 1 || rd_q.size() - rb != ROW || cv_q.size() - sb != NS || busy !== 1'b0) begin
      bad++; $display("FAIL sid: got done=%0d reads=%0d slices=%0d busy=%b want 1 %0d %0d 0",
                      done_n - d0, rd_q.size() - rb, cv_q.size() - sb, busy, ROW, NS);
    end
  endtask

  task automatic test_abort_start_idle();
    int rb = rd_q.size();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || rd_q.size() != rb) begin
      bad++; $display("FAIL abort_start: got busy=%b reads=%0d want 0 0", busy, rd_q.size() - rb);
    end
  endtask

  task automatic test_reset_mid();
    start_run();
    feed(6, 1, -1);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, err, src_rd, buf_rst_n, buf_en, core_last} !== 7'b0 || src_addr !== '0
        || core_valid !== '0 || core_data !== '0) begin
      bad++; $display("FAIL rst_mid: got ctrl=%b addr=%0d v=%b d=%h want all zero",
                      {busy, done, err, src_rd, buf_rst_n, buf_en, core_last}, src_addr,
                      core_valid, core_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0 || src_rd !== 1'b0 || buf_rst_n !== 1'b0) begin
      bad++; $display("FAIL rst_hold: got busy=%b rd=%b rstn=%b want 0 0 0", busy, src_rd, buf_rst_n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_nominal();
    test_core_ready(4'b1011, 2);
    for (int r = 0; r < 3; r++) test_core_ready(NC'($urandom()), 4);
    test_timeout();
    test_abort();
    test_start_in_drain();
    test_abort_start_idle();
    test_reset_mid();
    test_nominal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
